rxdeframe: RTL and testbench

Parametrised serial receive deframer; successor to the fixed 11-bit `rxshift` in the USRT receive path. It samples `i_Rx_Serial` on oversampled baud ticks from `baudgen` and majority-votes each bit. It strips start, parity and stop bits, then delivers a `DATA_BITS`-wide word with per-frame error flags. A one-entry holding register with a read handshake sits between the deframer and the bus.

---
 rtl/rxdeframe.sv | 196 +++++++++++++++++++
 tb/tb_rxdeframe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rxdeframe.sv
// Serial receive deframer: oversampled 2-of-3 bit voting, optional parity, one or
// two stop bits, and a one-entry holding register with a read handshake.
module rxdeframe #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 i_Pclk,
  input  logic                 i_Rst,
  input  logic                 i_Bclk,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Parity_En,
  input  logic                 i_Parity_Odd,
  input  logic                 i_Stop2,
  input  logic                 i_Read,
  output logic [DATA_BITS-1:0] o_Data,
  output logic                 o_Valid,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                 state_q;
  logic                   rx_meta_q, rx_sync_q, rx_s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_cnt_q;
  logic                   smp0_q, smp1_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   xor_q, perr_q, ferr_q;
  logic                   par_en_q, par_odd_q, stop2_q;
  logic                   samp0_s, samp1_s, vote_tick_s, end_tick_s, vote_s;
  logic                   done_s, done_ferr_s;
  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q, perr_out_q, ferr_out_q, ovr_q;

  assign rx_s = rx_sync_q;

  // Tick position within the current bit, vote, and frame-completion decode
  always_comb begin
    cnt_d       = (cnt_q == CW'(OVERSAMPLE - 1)) ? '0 : cnt_q + CW'(1);
    samp0_s     = i_Bclk && (cnt_d == CW'(OVERSAMPLE / 2 - 1));
    samp1_s     = i_Bclk && (cnt_d == CW'(OVERSAMPLE / 2));
    vote_tick_s = i_Bclk && (cnt_d == CW'(OVERSAMPLE / 2 + 1));
    end_tick_s  = i_Bclk && (cnt_d == CW'(OVERSAMPLE - 1));
    vote_s      = maj3(smp0_q, smp1_q, rx_s);
    done_s      = 1'b0;
    done_ferr_s = 1'b0;
    case (state_q)
      STOP1: begin
        if (vote_tick_s && !stop2_q) begin
          done_s      = 1'b1;
          done_ferr_s = !vote_s;
        end else begin
          done_s      = 1'b0;
        end
      end
      STOP2: begin
        if (vote_tick_s) begin
          done_s      = 1'b1;
          done_ferr_s = ferr_q | !vote_s;
        end else begin
          done_s      = 1'b0;
        end
      end
      default: begin
        done_s      = 1'b0;
        done_ferr_s = 1'b0;
      end
    endcase
  end

  // Synchroniser and deframing FSM
  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      smp0_q    <= 1'b1;
      smp1_q    <= 1'b1;
      shreg_q   <= '0;
      xor_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
      if (state_q != IDLE && i_Bclk) cnt_q <= cnt_d;
      if (samp0_s) smp0_q <= rx_s;
      if (samp1_s) smp1_q <= rx_s;
      case (state_q)
        IDLE: begin
          if (i_Bclk && !rx_s) begin
            par_en_q  <= i_Parity_En;
            par_odd_q <= i_Parity_Odd;
            stop2_q   <= i_Stop2;
            cnt_q     <= '0;
            state_q   <= START;
          end
        end
        START: begin
          if (vote_tick_s && vote_s) begin
            state_q <= IDLE;
          end else if (end_tick_s) begin
            bit_cnt_q <= '0;
            xor_q     <= 1'b0;
            perr_q    <= 1'b0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (vote_tick_s) begin
            shreg_q <= {vote_s, shreg_q[DATA_BITS-1:1]};
            xor_q   <= xor_q ^ vote_s;
          end
          if (end_tick_s) begin
            if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
              state_q <= par_en_q ? PARITY : STOP1;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        PARITY: begin
          if (vote_tick_s) perr_q <= ((xor_q ^ vote_s) != par_odd_q);
          if (end_tick_s) state_q <= STOP1;
        end
        STOP1: begin
          // Single stop bit returns at the vote so back-to-back frames resync
          if (vote_tick_s) begin
            ferr_q <= !vote_s;
            if (!stop2_q) state_q <= IDLE;
          end else if (end_tick_s && stop2_q) begin
            state_q <= STOP2;
          end
        end
        STOP2: begin
          if (vote_tick_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Holding register; a read in the completion cycle frees the slot first
  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else if (done_s) begin
      if (!valid_q || i_Read) begin
        data_q     <= shreg_q;
        valid_q    <= 1'b1;
        perr_out_q <= perr_q;
        ferr_out_q <= done_ferr_s;
        ovr_q      <= 1'b0;
      end else begin
        ovr_q      <= 1'b1;
      end
    end else if (i_Read && valid_q) begin
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end
  end

  assign o_Data       = data_q;
  assign o_Valid      = valid_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  assign o_Overrun    = ovr_q;

endmodule

// File: tb/tb_rxdeframe.sv
// Directed bench for rxdeframe: builds frames tick by tick on the serial line
// and checks the holding register against hand-computed values.
module tb_rxdeframe;

  logic       clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Bclk;
  logic       i_Rx_Serial = 1'b1;
  logic       i_Parity_En = 1'b0;
  logic       i_Parity_Odd = 1'b0;
  logic       i_Stop2 = 1'b0;
  logic       i_Read = 1'b0;
  logic [7:0] o_Data;
  logic       o_Valid, o_Parity_Err, o_Frame_Err, o_Overrun;
  logic [1:0] div = 2'd0;
  int         passed = 0;
  int         failed = 0;
  int         total = 0;

  rxdeframe #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .i_Pclk(clk), .i_Rst(i_Rst), .i_Bclk(i_Bclk), .i_Rx_Serial(i_Rx_Serial),
    .i_Parity_En(i_Parity_En), .i_Parity_Odd(i_Parity_Odd), .i_Stop2(i_Stop2),
    .i_Read(i_Read), .o_Data(o_Data), .o_Valid(o_Valid),
    .o_Parity_Err(o_Parity_Err), .o_Frame_Err(o_Frame_Err), .o_Overrun(o_Overrun)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) div <= div + 2'd1;
  assign i_Bclk = (div == 2'd3);

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the next clock edge on which i_Bclk is high
  task automatic wait_tick();
    @(negedge clk);
    while (!i_Bclk) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic send_level(input logic v, input int n);
    i_Rx_Serial = v;
    repeat (n) wait_tick();
  endtask

  // Start bit plus 8 data bits LSB first; glitch_bit gets a 1-tick low on its centre sample
  task automatic send_head(input logic [7:0] d, input int glitch_bit);
    send_level(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        send_level(1'b1, 8);
        send_level(1'b0, 1);
        send_level(1'b1, 7);
      end else begin
        send_level(d[i], 16);
      end
    end
  endtask

  task automatic pulse_read();
    i_Read = 1'b1;
    @(posedge clk);
    #1;
    i_Read = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {8'h00, o_Data}, 16'h0000);
    check("rst_valid", {15'h0, o_Valid}, 16'h0000);
    check("rst_perr", {15'h0, o_Parity_Err}, 16'h0000);
    check("rst_ferr", {15'h0, o_Frame_Err}, 16'h0000);
    check("rst_ovr", {15'h0, o_Overrun}, 16'h0000);
    i_Rst = 1'b0;
    send_level(1'b1, 4);

    // 8N1 0xA5
    send_head(8'hA5, -1);
    send_level(1'b1, 16);
    check("8n1_data", {8'h00, o_Data}, 16'h00A5);
    check("8n1_valid", {15'h0, o_Valid}, 16'h0001);
    check("8n1_perr", {15'h0, o_Parity_Err}, 16'h0000);
    check("8n1_ferr", {15'h0, o_Frame_Err}, 16'h0000);
    pulse_read();
    check("8n1_read_valid", {15'h0, o_Valid}, 16'h0000);
    check("8n1_read_data_kept", {8'h00, o_Data}, 16'h00A5);
    pulse_read();
    check("idle_read_noeffect", {15'h0, o_Valid}, 16'h0000);

    // 8E1 0x37 (five ones): parity bit 1 is correct, 0 is an error
    i_Parity_En = 1'b1;
    i_Parity_Odd = 1'b0;
    send_head(8'h37, -1);
    send_level(1'b1, 16);
    send_level(1'b1, 16);
    check("8e1_ok_data", {8'h00, o_Data}, 16'h0037);
    check("8e1_ok_perr", {15'h0, o_Parity_Err}, 16'h0000);
    check("8e1_ok_ferr", {15'h0, o_Frame_Err}, 16'h0000);
    pulse_read();
    send_head(8'h37, -1);
    send_level(1'b0, 16);
    send_level(1'b1, 16);
    check("8e1_bad_data", {8'h00, o_Data}, 16'h0037);
    check("8e1_bad_perr", {15'h0, o_Parity_Err}, 16'h0001);
    pulse_read();
    check("8e1_read_clears_perr", {15'h0, o_Parity_Err}, 16'h0000);

    // 8N2 0x5C with second stop bit low, then clean 0x01
    i_Parity_En = 1'b0;
    i_Stop2 = 1'b1;
    send_head(8'h5C, -1);
    send_level(1'b1, 16);
    send_level(1'b0, 16);
    send_level(1'b1, 20);
    check("8n2_data", {8'h00, o_Data}, 16'h005C);
    check("8n2_ferr", {15'h0, o_Frame_Err}, 16'h0001);
    pulse_read();
    send_head(8'h01, -1);
    send_level(1'b1, 32);
    check("8n2_clean_data", {8'h00, o_Data}, 16'h0001);
    check("8n2_clean_ferr", {15'h0, o_Frame_Err}, 16'h0000);
    check("8n2_clean_valid", {15'h0, o_Valid}, 16'h0001);
    pulse_read();

    // Noise: 5-tick low pulse is a false start; glitched 0xFF still decodes
    i_Stop2 = 1'b0;
    send_level(1'b0, 5);
    send_level(1'b1, 30);
    check("noise_no_valid", {15'h0, o_Valid}, 16'h0000);
    send_head(8'hFF, 3);
    send_level(1'b1, 16);
    check("glitch_data", {8'h00, o_Data}, 16'h00FF);
    check("glitch_valid", {15'h0, o_Valid}, 16'h0001);
    pulse_read();

    // Overrun: 0x11 then 0x22 back-to-back, no read
    send_head(8'h11, -1);
    send_level(1'b1, 16);
    send_head(8'h22, -1);
    send_level(1'b1, 16);
    check("ovr_data", {8'h00, o_Data}, 16'h0011);
    check("ovr_flag", {15'h0, o_Overrun}, 16'h0001);
    pulse_read();
    check("ovr_read_valid", {15'h0, o_Valid}, 16'h0000);
    check("ovr_read_flag", {15'h0, o_Overrun}, 16'h0000);

    // Completion coincides with a read: new word loads, no overrun
    send_head(8'h5A, -1);
    send_level(1'b1, 16);
    send_head(8'h96, -1);
    send_level(1'b1, 9);
    @(negedge clk);
    while (!i_Bclk) @(negedge clk);
    i_Read = 1'b1;
    @(posedge clk);
    #1;
    i_Read = 1'b0;
    check("rdcmp_data", {8'h00, o_Data}, 16'h0096);
    check("rdcmp_valid", {15'h0, o_Valid}, 16'h0001);
    check("rdcmp_ovr", {15'h0, o_Overrun}, 16'h0000);
    send_level(1'b1, 6);

    // Reset during data bit 4 of 0xC3, then 0x3C
    send_level(1'b0, 16);
    send_level(1'b1, 16);
    send_level(1'b1, 16);
    send_level(1'b0, 16);
    send_level(1'b0, 16);
    send_level(1'b0, 5);
    i_Rst = 1'b1;
    i_Rx_Serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_data", {8'h00, o_Data}, 16'h0000);
    check("midrst_valid", {15'h0, o_Valid}, 16'h0000);
    check("midrst_ovr", {15'h0, o_Overrun}, 16'h0000);
    i_Rst = 1'b0;
    send_level(1'b1, 20);
    check("midrst_idle_valid", {15'h0, o_Valid}, 16'h0000);
    send_head(8'h3C, -1);
    send_level(1'b1, 16);
    check("post_rst_data", {8'h00, o_Data}, 16'h003C);
    check("post_rst_valid", {15'h0, o_Valid}, 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
